// File: rtl/sqrt_scheduler.sv
// Round-robin scheduler sharing one combinational square_root among NUM_REQ requesters.
// Results are fixed point: rsp_data = floor(sqrt(operand) * 2^DATA_WIDTH), integer part in the upper half.

module square_root #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   operand,
    output logic [2*DATA_WIDTH-1:0] root
);
    localparam int unsigned ROOT_W = 2 * DATA_WIDTH;
    localparam int unsigned RAD_W  = 2 * ROOT_W;
    localparam int unsigned REM_W  = ROOT_W + 2;

    logic [RAD_W-1:0]  rad;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  trial;
    logic [ROOT_W-1:0] acc;

    // Digit-by-digit restoring root of operand scaled by 2^(2*DATA_WIDTH)
    always_comb begin
        rad   = RAD_W'(operand) << ROOT_W;
        rem   = '0;
        trial = '0;
        acc   = '0;
        for (int i = ROOT_W - 1; i >= 0; i--) begin
            rem   = {rem[REM_W-3:0], rad[2*i +: 2]};
            trial = {acc, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                acc = {acc[ROOT_W-2:0], 1'b1};
            end else begin
                acc = {acc[ROOT_W-2:0], 1'b0};
            end
        end
        root = acc;
    end
endmodule

module sqrt_scheduler #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    input  logic                            rsp_ready
);
    localparam int unsigned RES_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                state, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_idx, search_idx;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] operand, operand_d, grant_data;
    logic [ID_WIDTH-1:0]   rsp_id_d;
    logic [RES_W-1:0]      rsp_data_d, root;
    logic                  rsp_valid_d;

    square_root #(.DATA_WIDTH(DATA_WIDTH)) u_root (
        .operand (operand),
        .root    (root)
    );

    // Rotating-priority search; index arithmetic wraps because NUM_REQ is a power of two
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            search_idx = rr_ptr + ID_WIDTH'(k);
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        operand_d   = operand;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_valid_d = rsp_valid;
        req_ready   = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    operand_d = grant_data;
                    rsp_id_d  = grant_idx;
                    rr_ptr_d  = grant_idx + ID_WIDTH'(1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_data_d  = root;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // No grant may be issued while reset is held
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            operand   <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            operand   <= operand_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_valid <= rsp_valid_d;
        end
    end
endmodule

// File: doc/sqrt_scheduler.md
# sqrt_scheduler

Round-robin scheduler that shares one combinational `square_root` instance among `NUM_REQ` requesters (sensor-processing channels of the baggage-drop datapath). Accepts one operand per transaction through a valid/ready handshake, registers the operand, captures the `square_root` result one cycle later and returns it tagged with the requester ID. It sits between the sensor/height logic and the single `square_root` unit, so only one root block is instantiated for the whole design.

## Interface
- `DATA_WIDTH`, default 8: operand width; result width is `2*DATA_WIDTH`, as produced by `square_root`.
- `NUM_REQ`, default 4: number of requesters; power of two, at least 2.
- `ID_WIDTH`, default 2: log2(`NUM_REQ`); width of the response tag.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request strobe; bit i belongs to requester i.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  `NUM_REQ`  one-hot grant; a handshake completes on a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  `ID_WIDTH`  index of the requester that owns the result.
- `rsp_data`  out  `2*DATA_WIDTH`  `square_root` output for the granted operand.
- `rsp_ready`  in  1  consumer accepts the result.

## Operation
- State machine:
  - `IDLE`: arbitration is active.
  - `CALC`: the operand register drives `square_root`; its output is captured into the `rsp_data` register at the end of the cycle.
  - `RESP`: `rsp_valid`=1 and is held until `rsp_ready`.
- Transitions:
  - `IDLE`->`CALC` when any `req_valid` is high.
  - `CALC`->`RESP` always.
  - `RESP`->`IDLE` when `rsp_ready`=1; otherwise stay in `RESP`.
- Arbitration:
  - Search starts at `rr_ptr`, then `rr_ptr+1`, and so on, wrapping modulo `NUM_REQ`. The first requester with `req_valid` high is granted (g).
  - `req_ready[g]` is combinational: it is high only in `IDLE`, and only for g.
  - On the grant, the operand slice g is latched into the operand register, g is latched into `rsp_id`, and `rr_ptr` becomes (g+1) mod `NUM_REQ`.
- Requesters hold `req_valid` and `req_data` stable until they are granted. A requester may drop `req_valid` before it is granted; no grant is then issued to it.
- `req_ready` is all-zero in `CALC` and `RESP`. New requests are never accepted while a result is pending, so there is no overlap or queueing.
- `rsp_data` is exactly the `square_root` output for the latched operand. No truncation, rounding or reformatting.
- `rsp_id` and `rsp_data` stay stable for as long as `rsp_valid` is high.
- Reset (valid in any state, including mid-`CALC` or `RESP`):
  - state returns to `IDLE`, `rr_ptr`=0;
  - the operand register, `rsp_id` and `rsp_data` are cleared to 0;
  - any pending result is discarded and never presented.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `req_ready`=0 during the reset cycle. `req_ready` is forced low while `rst` is high.
- Latency: grant handshake at cycle N -> `CALC` at N+1 -> `rsp_valid`=1 at N+2.
- With `rsp_ready` held high, the earliest next grant is at N+3. Peak throughput is one result per 3 cycles.
- `rsp_ready` sampled at cycle M with `rsp_valid`=1: `rsp_valid`=0 at M+1, and arbitration runs in the same cycle M+1.
- `rsp_ready` while `rsp_valid`=0 is ignored.
- Fairness: a requester holding `req_valid` continuously is granted within `NUM_REQ` transactions.

## Test plan
- Single request, idle start: `req_valid`=0001, `req_data[7:0]`=16.
  - `req_ready`=0001 the same cycle.
  - 2 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=`ref_square_root`(16).
- All four valid at once after reset, operands 0, 1, 255, 100, `rsp_ready`=1.
  - Grants in order 0,1,2,3, each 3 cycles apart.
  - Results match `ref_square_root` and carry ids 0,1,2,3.
- Rotation after a grant to requester 2 (`rr_ptr`=3), then `req_valid`=1001.
  - Requester 3 is granted first, then requester 0.
- Backpressure: `rsp_ready`=0 for 5 cycles while in `RESP`, with other requests pending.
  - `rsp_valid`, `rsp_id` and `rsp_data` are held unchanged; `req_ready`=0 throughout.
  - `rsp_ready`=1 releases the result, and the next grant follows the cycle after.
- Reset mid-`RESP`: assert `rst` for 1 cycle.
  - Next cycle `rsp_valid`=0, `rsp_data`=0.
  - The stale result is never re-presented.
  - The first new grant goes to the lowest valid index starting from 0.
- Exhaustive sweep: operands 0..255 through rotating requesters with random `rsp_ready` stalls.
  - Every result equals `ref_square_root`.
  - No lost or duplicated transaction.
  - Every `rsp_id` matches its source.
